tap_accumulator: RTL and testbench



---
 rtl/tap_acc_pkg.sv | 21 ++
 rtl/tap_accumulator_if.sv | 28 ++
 rtl/tap_accumulator_round_clip.sv | 31 +++
 rtl/tap_accumulator.sv | 82 ++++++++
 tb/tb_tap_accumulator.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tap_acc_pkg.sv
// rtl/tap_acc_pkg.sv - shared widths and warm-up count encoding for tap_accumulator
package tap_acc_pkg;

    localparam int W_PROD    = 16;
    localparam int ACC_W     = 19;
    localparam int SHIFT_DEF = 6;
    localparam int OUT_W_DEF = 8;
    localparam int CNT_W     = 2;

    typedef logic [CNT_W-1:0] cnt_t;

    // Number of samples already folded into the transposed chain, saturating at full.
    localparam cnt_t CNT_IDLE = 2'd0;
    localparam cnt_t CNT_ONE  = 2'd1;
    localparam cnt_t CNT_FULL = 2'd3;

    function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [W_PROD-1:0] p);
        return ACC_W'(p);
    endfunction

endpackage

// File: rtl/tap_accumulator_if.sv
// rtl/tap_accumulator_if.sv - product-set input stream and filtered-sample output stream
interface tap_accumulator_if #(
    parameter int OUT_W = tap_acc_pkg::OUT_W_DEF
);
    logic                                     in_valid;
    logic                                     in_ready;
    logic                                     in_first;
    logic                                     in_last;
    logic signed [tap_acc_pkg::W_PROD-1:0]    p0;
    logic signed [tap_acc_pkg::W_PROD-1:0]    p1;
    logic signed [tap_acc_pkg::W_PROD-1:0]    p2;
    logic signed [tap_acc_pkg::W_PROD-1:0]    p3;
    logic                                     out_valid;
    logic                                     out_ready;
    logic [OUT_W-1:0]                         out_data;
    logic                                     out_last;

    modport master (
        output in_valid, in_first, in_last, p0, p1, p2, p3, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_first, in_last, p0, p1, p2, p3, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/tap_accumulator_round_clip.sv
// rtl/tap_accumulator_round_clip.sv - round, arithmetic shift and clip an accumulated sum to a sample
module round_clip
    import tap_acc_pkg::*;
#(
    parameter int SHIFT = SHIFT_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic [OUT_W-1:0]        sample
);

    localparam logic signed [ACC_W:0] RND   = (ACC_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((1 << OUT_W) - 1);

    logic signed [ACC_W:0] rounded;
    logic signed [ACC_W:0] shifted;

    // One guard bit so the rounding offset cannot wrap the most positive sum.
    always_comb begin
        rounded = {sum[ACC_W-1], sum} + RND;
        shifted = rounded >>> SHIFT;
        if (shifted < 0) begin
            sample = '0;
        end else if (shifted > MAX_V) begin
            sample = '1;
        end else begin
            sample = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/tap_accumulator.sv
// rtl/tap_accumulator.sv - transposed 4-tap accumulation of MCM products into clipped predicted samples
module tap_accumulator
    import tap_acc_pkg::*;
#(
    parameter int SHIFT = SHIFT_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input logic               clk,
    input logic               rst_n,
    tap_accumulator_if.slave  bus
);

    logic signed [ACC_W-1:0] r1, r2, r3;
    logic signed [ACC_W-1:0] base1, base2, base3;
    logic signed [ACC_W-1:0] sum;
    cnt_t                    count, count_n;
    logic                    accept;
    logic                    produce;
    logic [OUT_W-1:0]        sample;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign produce      = accept && !bus.in_first && (count == CNT_FULL);

    // A new line starts from an empty chain regardless of what the old line left behind.
    assign base1 = bus.in_first ? '0 : r1;
    assign base2 = bus.in_first ? '0 : r2;
    assign base3 = bus.in_first ? '0 : r3;
    assign sum   = base1 + sext_prod(bus.p0);

    always_comb begin
        count_n = count;
        if (accept) begin
            if (bus.in_last) begin
                count_n = CNT_IDLE;
            end else if (bus.in_first || count == CNT_IDLE) begin
                count_n = CNT_ONE;
            end else if (count != CNT_FULL) begin
                count_n = count + CNT_ONE;
            end
        end
    end

    round_clip #(
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_clip (
        .sum    (sum),
        .sample (sample)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1    <= '0;
            r2    <= '0;
            r3    <= '0;
            count <= CNT_IDLE;
        end else begin
            count <= count_n;
            if (accept) begin
                r3 <= sext_prod(bus.p3);
                r2 <= base3 + sext_prod(bus.p2);
                r1 <= base2 + sext_prod(bus.p1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
        end else if (produce) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= sample;
            bus.out_last  <= bus.in_last;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tap_accumulator.sv
// tb/tb_tap_accumulator.sv - scoreboard bench for tap_accumulator against a direct-form model
`timescale 1ns/100ps
module tb_tap_accumulator;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    int   hold_cnt = 0;
    bit   rnd_mode = 0;
    int   exp_q[$];
    int   mp0[$], mp1[$], mp2[$], mp3[$];

    tap_accumulator_if #(.OUT_W(8)) bus ();

    tap_accumulator #(.SHIFT(6), .OUT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int round_clip_ref(input int y);
        int v;
        int r;
        v = y + 32;
        if (v >= 0) r = v / 64;
        else        r = -((-v + 63) / 64);
        if (r < 0)   r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    task automatic model_clear();
        mp0.delete(); mp1.delete(); mp2.delete(); mp3.delete();
    endtask

    // Direct form: y[n] = p0(x[n]) + p1(x[n-1]) + p2(x[n-2]) + p3(x[n-3]).
    task automatic model_accept(input int a0, a1, a2, a3, input bit first, input bit last);
        int y;
        if (first) model_clear();
        mp0.push_back(a0); mp1.push_back(a1); mp2.push_back(a2); mp3.push_back(a3);
        if (mp0.size() > 4) begin
            void'(mp0.pop_front()); void'(mp1.pop_front());
            void'(mp2.pop_front()); void'(mp3.pop_front());
        end
        if (mp0.size() == 4) begin
            y = mp0[3] + mp1[2] + mp2[1] + mp3[0];
            exp_q.push_back(round_clip_ref(y) | (int'(last) << 8));
        end
        if (last) model_clear();
    endtask

    initial begin
        bus.out_ready = 1;
        forever begin
            @(negedge clk);
            if (hold_cnt > 0) begin
                bus.out_ready = 0;
                hold_cnt--;
            end else if (rnd_mode) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.out_ready = 1;
            end
        end
    end

    initial begin
        bit stalled;
        int held_data;
        int held_last;
        int e;
        stalled = 0;
        held_data = 0;
        held_last = 0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                stalled = 0;
            end else begin
                check("in_ready", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
                if (stalled) begin
                    check("hold_valid", int'(bus.out_valid), 1);
                    check("hold_data", int'(bus.out_data), held_data);
                    check("hold_last", int'(bus.out_last), held_last);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", int'(bus.out_data), e & 255);
                        check("out_last", int'(bus.out_last), e >> 8);
                    end
                    n_out++;
                    stalled = 0;
                end else if (bus.out_valid) begin
                    stalled = 1;
                    held_data = int'(bus.out_data);
                    held_last = int'(bus.out_last);
                end else begin
                    stalled = 0;
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic send_sample(input int a0, a1, a2, a3, input bit first, input bit last);
        int waited;
        waited = 0;
        bus.in_valid = 1;
        bus.in_first = first;
        bus.in_last  = last;
        bus.p0 = 16'(a0);
        bus.p1 = 16'(a1);
        bus.p2 = 16'(a2);
        bus.p3 = 16'(a3);
        forever begin
            #1;
            if (bus.in_ready) begin
                model_accept(a0, a1, a2, a3, first, last);
                @(negedge clk);
                break;
            end
            waited++;
            if (waited > 200) begin
                check("send_timeout", waited, 0);
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        bus.in_valid = 0;
        bus.in_first = 0;
        bus.in_last  = 0;
        @(negedge clk);
    endtask

    function automatic int rprod();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic run_line(input int n, input bit rnd, input int a0, a1, a2, a3,
                            input bit use_first, input bit use_last, input int hold_at);
        for (int i = 0; i < n; i++) begin
            if (i == hold_at) hold_cnt = 5;
            if (rnd) send_sample(rprod(), rprod(), rprod(), rprod(), use_first && i == 0, use_last && i == n - 1);
            else     send_sample(a0, a1, a2, a3, use_first && i == 0, use_last && i == n - 1);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        idle();
        while ((exp_q.size() != 0 || bus.out_valid) && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) check("drain_timeout", w, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int base;
        rst_n = 0;
        bus.in_valid = 0;
        bus.in_first = 0;
        bus.in_last  = 0;
        bus.p0 = 0; bus.p1 = 0; bus.p2 = 0; bus.p3 = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_out_last", int'(bus.out_last), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        base = n_out;
        run_line(6, 0, -300, -200, 1200, 400, 1, 1, -1);
        drain();
        check("const_line_outs", n_out - base, 3);

        base = n_out;
        run_line(4, 0, -1000, 0, 0, 0, 1, 1, -1);
        run_line(4, 0, 32767, 32767, 32767, 32767, 1, 1, -1);
        drain();
        check("clip_line_outs", n_out - base, 2);

        base = n_out;
        run_line(12, 1, 0, 0, 0, 0, 1, 1, 5);
        drain();
        check("backpressure_outs", n_out - base, 9);

        base = n_out;
        run_line(3, 1, 0, 0, 0, 0, 1, 1, -1);
        send_sample(rprod(), rprod(), rprod(), rprod(), 1, 1);
        run_line(2, 1, 0, 0, 0, 0, 1, 0, -1);
        run_line(4, 1, 0, 0, 0, 0, 1, 1, -1);
        drain();
        check("short_lines_outs", n_out - base, 1);

        rnd_mode = 1;
        for (int k = 0; k < 16; k++) begin
            run_line($urandom_range(1, 9), 1, 0, 0, 0, 0,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, -1);
            if ($urandom_range(0, 1) != 0) idle();
        end
        rnd_mode = 0;
        drain();

        run_line(5, 1, 0, 0, 0, 0, 1, 0, -1);
        bus.in_valid = 0;
        #1;
        check("pre_rst_valid", int'(bus.out_valid), 1);
        rst_n = 0;
        #1;
        check("async_rst_valid", int'(bus.out_valid), 0);
        check("async_rst_data", int'(bus.out_data), 0);
        exp_q.delete();
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        base = n_out;
        run_line(3, 1, 0, 0, 0, 0, 0, 0, -1);
        idle();
        idle();
        check("warmup_no_out", n_out - base, 0);
        run_line(1, 1, 0, 0, 0, 0, 0, 1, -1);
        drain();
        check("post_rst_outs", n_out - base, 1);

        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
